// File: rtl/alu_control_md.sv
// ALU control decoder with an iterative multiply/divide unit that owns HI/LO.
// Decode is purely combinational; the MD unit is a three-state FSM, one bit per cycle.
module alu_control_md #(
  parameter int NBITS        = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_Valid,
  input  logic [ANBITS-1:0]       i_Funct,
  input  logic [ANBITS-1:0]       i_Opcode,
  input  logic [NBITSCONTROL-1:0] i_ALUOp,
  input  logic [NBITS-1:0]        i_A,
  input  logic [NBITS-1:0]        i_B,
  output logic [ALUOP-1:0]        o_ALUOp,
  output logic                    o_Illegal,
  output logic [NBITS-1:0]        o_HI,
  output logic [NBITS-1:0]        o_LO,
  output logic                    o_Busy,
  output logic                    o_Stall,
  output logic                    o_DivZero
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [NBITSCONTROL-1:0] CLS_ADD   = NBITSCONTROL'(0);
  localparam logic [NBITSCONTROL-1:0] CLS_SUB   = NBITSCONTROL'(1);
  localparam logic [NBITSCONTROL-1:0] CLS_FUNCT = NBITSCONTROL'(2);

  localparam logic [ALUOP-1:0] OP_AND = ALUOP'(4'b0000);
  localparam logic [ALUOP-1:0] OP_OR  = ALUOP'(4'b0001);
  localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(4'b0010);
  localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(4'b0110);
  localparam logic [ALUOP-1:0] OP_SLT = ALUOP'(4'b0111);
  localparam logic [ALUOP-1:0] OP_NOR = ALUOP'(4'b1100);
  localparam logic [ALUOP-1:0] OP_XOR = ALUOP'(4'b1101);
  localparam logic [ALUOP-1:0] OP_MD  = ALUOP'(4'b1111);

  localparam logic [ANBITS-1:0] F_ADD   = ANBITS'(6'b100000);
  localparam logic [ANBITS-1:0] F_ADDU  = ANBITS'(6'b100001);
  localparam logic [ANBITS-1:0] F_SUB   = ANBITS'(6'b100010);
  localparam logic [ANBITS-1:0] F_SUBU  = ANBITS'(6'b100011);
  localparam logic [ANBITS-1:0] F_AND   = ANBITS'(6'b100100);
  localparam logic [ANBITS-1:0] F_OR    = ANBITS'(6'b100101);
  localparam logic [ANBITS-1:0] F_XOR   = ANBITS'(6'b100110);
  localparam logic [ANBITS-1:0] F_NOR   = ANBITS'(6'b100111);
  localparam logic [ANBITS-1:0] F_SLT   = ANBITS'(6'b101010);
  localparam logic [ANBITS-1:0] F_MULT  = ANBITS'(6'b011000);
  localparam logic [ANBITS-1:0] F_MULTU = ANBITS'(6'b011001);
  localparam logic [ANBITS-1:0] F_DIV   = ANBITS'(6'b011010);
  localparam logic [ANBITS-1:0] F_DIVU  = ANBITS'(6'b011011);
  localparam logic [ANBITS-1:0] F_MFHI  = ANBITS'(6'b010000);
  localparam logic [ANBITS-1:0] F_MTHI  = ANBITS'(6'b010001);
  localparam logic [ANBITS-1:0] F_MFLO  = ANBITS'(6'b010010);
  localparam logic [ANBITS-1:0] F_MTLO  = ANBITS'(6'b010011);

  localparam logic [ANBITS-1:0] O_ADDI  = ANBITS'(6'b001000);
  localparam logic [ANBITS-1:0] O_ADDIU = ANBITS'(6'b001001);
  localparam logic [ANBITS-1:0] O_SLTI  = ANBITS'(6'b001010);
  localparam logic [ANBITS-1:0] O_ANDI  = ANBITS'(6'b001100);
  localparam logic [ANBITS-1:0] O_ORI   = ANBITS'(6'b001101);
  localparam logic [ANBITS-1:0] O_XORI  = ANBITS'(6'b001110);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*NBITS-1:0] acc_q;
  logic [NBITS-1:0]   m_q;
  logic               is_div_q, neg_q, neg_rem_q;
  logic [NBITS-1:0]   hi_q, lo_q;
  logic               busy_q, divzero_q;

  logic [ALUOP-1:0]   dec_op;
  logic               dec_ill;
  logic               is_md_fn, is_muldiv_fn, is_div_fn, is_signed_fn;
  logic               md_req;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dec_op       = OP_MD;
    dec_ill      = 1'b1;
    is_md_fn     = 1'b0;
    is_muldiv_fn = 1'b0;
    case (i_ALUOp)
      CLS_ADD: begin dec_op = OP_ADD; dec_ill = 1'b0; end
      CLS_SUB: begin dec_op = OP_SUB; dec_ill = 1'b0; end
      CLS_FUNCT: begin
        case (i_Funct)
          F_ADD, F_ADDU: begin dec_op = OP_ADD; dec_ill = 1'b0; end
          F_SUB, F_SUBU: begin dec_op = OP_SUB; dec_ill = 1'b0; end
          F_AND:         begin dec_op = OP_AND; dec_ill = 1'b0; end
          F_OR:          begin dec_op = OP_OR;  dec_ill = 1'b0; end
          F_XOR:         begin dec_op = OP_XOR; dec_ill = 1'b0; end
          F_NOR:         begin dec_op = OP_NOR; dec_ill = 1'b0; end
          F_SLT:         begin dec_op = OP_SLT; dec_ill = 1'b0; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            dec_ill      = 1'b0;
            is_md_fn     = 1'b1;
            is_muldiv_fn = 1'b1;
          end
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin
            dec_ill  = 1'b0;
            is_md_fn = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        case (i_Opcode)
          O_ADDI, O_ADDIU: begin dec_op = OP_ADD; dec_ill = 1'b0; end
          O_SLTI:          begin dec_op = OP_SLT; dec_ill = 1'b0; end
          O_ANDI:          begin dec_op = OP_AND; dec_ill = 1'b0; end
          O_ORI:           begin dec_op = OP_OR;  dec_ill = 1'b0; end
          O_XORI:          begin dec_op = OP_XOR; dec_ill = 1'b0; end
          default: ;
        endcase
      end
    endcase
  end

  assign md_req       = i_Valid & (i_ALUOp == CLS_FUNCT) & is_md_fn;
  assign is_div_fn    = (i_Funct == F_DIV) | (i_Funct == F_DIVU);
  assign is_signed_fn = (i_Funct == F_MULT) | (i_Funct == F_DIV);

  assign o_ALUOp   = dec_op;
  assign o_Illegal = dec_ill & i_Valid;
  assign o_HI      = hi_q;
  assign o_LO      = lo_q;
  assign o_Busy    = busy_q;
  assign o_DivZero = divzero_q;
  assign o_Stall   = busy_q & md_req;

  // Signed ops run on magnitudes; the most negative value maps to 2^(NBITS-1) unsigned.
  logic [NBITS-1:0] a_mag, b_mag;
  always_comb begin
    a_mag = (is_signed_fn && i_A[NBITS-1]) ? -i_A : i_A;
    b_mag = (is_signed_fn && i_B[NBITS-1]) ? -i_B : i_B;
  end

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [NBITS:0]     mul_sum, div_shift, div_diff;
  logic [2*NBITS-1:0] acc_step;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*NBITS-1:NBITS]} + (acc_q[0] ? {1'b0, m_q} : {(NBITS+1){1'b0}});
    div_shift = {acc_q[2*NBITS-1:NBITS], acc_q[NBITS-1]};
    div_diff  = div_shift - {1'b0, m_q};
    if (is_div_q) begin
      if (!div_diff[NBITS]) acc_step = {div_diff[NBITS-1:0], acc_q[NBITS-2:0], 1'b1};
      else                  acc_step = {div_shift[NBITS-1:0], acc_q[NBITS-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[NBITS-1:1]};
    end
  end

  logic [2*NBITS-1:0] prod_fix;
  logic [NBITS-1:0]   quo_fix, rem_fix;
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[NBITS-1:0] : acc_q[NBITS-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*NBITS-1:NBITS] : acc_q[2*NBITS-1:NBITS];
  end

  always_ff @(posedge i_clk) begin
    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      divzero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md_req) begin
            if (is_muldiv_fn) begin
              if (is_div_fn && (i_B == '0)) begin
                divzero_q <= 1'b1;
              end else begin
                state_q   <= S_RUN;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                is_div_q  <= is_div_fn;
                acc_q     <= {{NBITS{1'b0}}, (is_div_fn ? a_mag : b_mag)};
                m_q       <= is_div_fn ? b_mag : a_mag;
                neg_q     <= is_signed_fn & (i_A[NBITS-1] ^ i_B[NBITS-1]);
                neg_rem_q <= is_signed_fn & is_div_fn & i_A[NBITS-1];
              end
            end else if (i_Funct == F_MTHI) begin
              hi_q <= i_A;
            end else if (i_Funct == F_MTLO) begin
              lo_q <= i_A;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NBITS-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*NBITS-1:NBITS];
            lo_q <= prod_fix[NBITS-1:0];
          end
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_control_md.md
ALU_CONTROL_MD -- requirements
Module: alu_control_md

Interface
REQ-001 SHALL have parameter NBITS, default 32, operand/HI/LO data width (even, >= 8).
REQ-002 SHALL have parameter ANBITS, default 6, width of funct and opcode fields.
REQ-003 SHALL have parameter NBITSCONTROL, default 2, width of main-control ALU class code.
REQ-004 SHALL have parameter ALUOP, default 4, width of ALU operation code.
REQ-005 SHALL use one clock; reset is synchronous and active-high: i_clk  in  1  rising-edge clock; i_reset  in  1  synchronous active-high reset.
REQ-006 SHALL have i_Valid  in  1  instruction in decode slot is real (not bubble).
REQ-007 SHALL have i_Funct  in  ANBITS  funct field; i_Opcode  in  ANBITS  opcode field; i_ALUOp  in  NBITSCONTROL  class code.
REQ-008 SHALL have i_A, i_B  in  NBITS  rs/rt operands.
REQ-009 SHALL have o_ALUOp  out  ALUOP  ALU operation; o_Illegal  out  1  undecodable op.
REQ-010 SHALL have o_HI, o_LO  out  NBITS  HI/LO registers; o_Busy  out  1  multiply/divide running.
REQ-011 SHALL have o_Stall  out  1  hold pipeline; o_DivZero  out  1  one-cycle divide-by-zero pulse.

Function
REQ-012 o_ALUOp/o_Illegal SHALL be combinational: class 00 -> 0010; 01 -> 0110; 10 decode funct; 11 decode opcode.
REQ-013 Funct decode: ADD/ADDU 10000x -> 0010; SUB/SUBU 10001x -> 0110; AND 100100 -> 0000; OR 100101 -> 0001; XOR 100110 -> 1101; NOR 100111 -> 1100; SLT 101010 -> 0111.
REQ-014 Opcode decode: ADDI 001000, ADDIU 001001 -> 0010; SLTI 001010 -> 0111; ANDI 001100 -> 0000; ORI 001101 -> 0001; XORI 001110 -> 1101.
REQ-015 MD functs MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011 SHALL give o_ALUOp 1111, o_Illegal 0.
REQ-016 Any other funct/opcode SHALL give o_ALUOp 1111, o_Illegal 1 (ignored when i_Valid=0).
REQ-017 MD request = i_Valid & i_ALUOp==10 & funct in REQ-015 set.
REQ-018 FSM states IDLE, RUN, FIX; IDLE -> RUN on MULT/MULTU/DIV/DIVU request accepted in IDLE; RUN -> FIX when cycle counter reaches NBITS-1; FIX -> IDLE unconditionally.
REQ-019 RUN SHALL be exactly NBITS cycles: iterative shift-add multiply / restoring divide on operand magnitudes, one bit per cycle, internal counter of clog2(NBITS) bits.
REQ-020 FIX SHALL apply sign correction (signed ops) and write HI/LO; accepted at edge k -> HI/LO visible after edge k+NBITS+1.
REQ-021 Signed multiply: {HI,LO} = full 2*NBITS two's-complement product; unsigned: full unsigned product.
REQ-022 Divide: LO = quotient truncated toward zero, HI = remainder with sign of dividend; signed MIN / -1 SHALL give LO = MIN, HI = 0.
REQ-023 Divide with i_B==0 SHALL stay IDLE, leave HI/LO unchanged, pulse o_DivZero for the cycle after acceptance.
REQ-024 o_Busy SHALL be 1 exactly in RUN and FIX.
REQ-025 o_Stall SHALL be combinational: o_Busy & any MD request; non-MD instructions never stall.
REQ-026 MTHI/MTLO in IDLE SHALL write i_A to HI/LO at that edge; MFHI/MFLO in IDLE read current o_HI/o_LO (no internal forwarding).
REQ-027 Operands SHALL be latched at acceptance; i_A/i_B changes during RUN SHALL not affect the result.
REQ-028 MD request stalled while busy SHALL be accepted the cycle after FIX (state IDLE), using operands then present.

Reset
REQ-029 i_reset at an edge SHALL force IDLE, counter 0, o_HI=o_LO=0, o_Busy=0, o_DivZero=0, aborting any RUN/FIX with no HI/LO write; reset dominates a simultaneous request.

Verification
REQ-030 MULTU A=FFFFFFFF B=00000002 -> o_Busy 33 cycles; after edge k+33 HI=00000001, LO=FFFFFFFE.
REQ-031 MULT A=FFFFFFFD B=00000005 -> HI=FFFFFFFF, LO=FFFFFFF1; MULT 80000000*80000000 -> HI=40000000, LO=00000000.
REQ-032 DIV A=FFFFFFF9 B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
REQ-033 DIVU B=0 with HI=1234, LO=5678 -> o_DivZero=1 one cycle, o_Busy never 1, HI/LO unchanged.
REQ-034 MFLO issued 1 cycle after MULT -> o_Stall=1 until FIX completes, then 0 with o_LO showing product; ADD during busy -> o_Stall=0, o_ALUOp=0010.
REQ-035 i_reset asserted mid-RUN -> next cycle IDLE, o_Busy=0, HI=LO=0; new MULT then completes normally.
